// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_pkg
// Brief    : Shared constants and helpers for the UART receive subsystem.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // cfg_dbit 00..11 selects 5..8 data bits; last bit index is 4 + code.
    localparam logic [2:0] DBIT_LAST_BASE = 3'd4;

    // Entry layout: {frame_err, parity_err, data[7:0]}.
    localparam int ENTRY_W = 8 + 2;

    function automatic logic [2:0] last_data_bit(input logic [1:0] dbit);
        return DBIT_LAST_BASE + {1'b0, dbit};
    endfunction

    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == PAR_EVEN) || (par == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo.sv
`default_nettype none
// ============================================================================
// Module   : fifo
// Brief    : Show-ahead synchronous FIFO, 2**W entries of B bits.
// Revision : 1.0 - initial release
// ============================================================================
module fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_rd,
    input  logic         i_wr,
    input  logic [B-1:0] i_wdata,
    output logic         o_empty,
    output logic         o_full,
    output logic [B-1:0] o_rdata
);

    localparam int DEPTH = 2 ** W;

    logic [B-1:0] r_mem [DEPTH];
    logic [W:0]   r_wptr;
    logic [W:0]   r_rptr;
    logic         w_empty;
    logic         w_full;
    logic         w_wr_en;
    logic         w_rd_en;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[W] != r_rptr[W]) && (r_wptr[W-1:0] == r_rptr[W-1:0]);

    // A full FIFO still accepts a write when the head is popped in the same cycle.
    assign w_wr_en = i_wr && (!w_full || i_rd);
    assign w_rd_en = i_rd && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + 1'b1;
            if (w_rd_en) r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wptr[W-1:0]] <= i_wdata;
    end

    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_rdata = w_empty ? '0 : r_mem[r_rptr[W-1:0]];

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Brief    : Configurable-frame UART receiver with baud generator, rx
//            synchroniser and error-tagged receive FIFO with overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DVSR_WIDTH = 16,
    parameter int FIFO_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic [DVSR_WIDTH-1:0] cfg_dvsr,
    input  logic [1:0]            cfg_dbit,
    input  logic [1:0]            cfg_parity,
    input  logic                  cfg_stop2,
    input  logic                  rd_uart,
    output logic [7:0]            rd_data,
    output logic                  rd_parity_err,
    output logic                  rd_frame_err,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic                  overrun,
    input  logic                  clr_overrun
);

    localparam int             S_W         = $clog2(OVERSAMPLE);
    localparam logic [S_W-1:0] S_HALF_LAST = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0] S_LAST      = S_W'(OVERSAMPLE - 1);

    // ---------------- baud tick ----------------
    logic [DVSR_WIDTH-1:0] r_tick_cnt;
    logic [DVSR_WIDTH-1:0] w_tick_lim;
    logic                  w_s_tick;

    always_comb begin
        w_tick_lim = (cfg_dvsr > DVSR_WIDTH'(1)) ? (cfg_dvsr - DVSR_WIDTH'(1)) : '0;
        w_s_tick   = (r_tick_cnt >= w_tick_lim);
    end

    always_ff @(posedge clk) begin
        if (rst || w_s_tick) r_tick_cnt <= '0;
        else                 r_tick_cnt <= r_tick_cnt + DVSR_WIDTH'(1);
    end

    // ---------------- rx synchroniser ----------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ---------------- receiver FSM ----------------
    state_t         r_state;
    logic [S_W-1:0] r_s_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic [2:0]     r_dbit_last;
    logic [1:0]     r_par_mode;
    logic           r_stop2;
    logic           r_par_err;
    logic           r_frame_err;

    logic           w_sample;
    logic [2:0]     w_stop_last;
    logic           w_par_xor;
    logic           w_par_err;
    logic           w_push;
    logic           w_push_frame_err;
    logic [ENTRY_W-1:0] w_entry;

    always_comb begin
        w_sample         = w_s_tick && (r_s_cnt == S_LAST);
        w_stop_last      = r_stop2 ? 3'd1 : 3'd0;
        w_par_xor        = (^r_shift) ^ r_rx_sync;
        w_par_err        = (r_par_mode == PAR_ODD) ? ~w_par_xor : w_par_xor;
        w_push           = (r_state == ST_STOP) && w_sample && (r_bit_cnt == w_stop_last);
        // The final stop bit is sampled in the push cycle, so fold it in here.
        w_push_frame_err = r_frame_err | ~r_rx_sync;
        w_entry          = {w_push_frame_err, r_par_err, r_shift};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_s_cnt     <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_dbit_last <= '0;
            r_par_mode  <= PAR_NONE;
            r_stop2     <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state     <= ST_START;
                        r_s_cnt     <= '0;
                        r_bit_cnt   <= '0;
                        r_shift     <= '0;
                        r_dbit_last <= last_data_bit(cfg_dbit);
                        r_par_mode  <= cfg_parity;
                        r_stop2     <= cfg_stop2;
                        r_par_err   <= 1'b0;
                        r_frame_err <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_s_tick) begin
                        if (r_s_cnt == S_HALF_LAST) begin
                            r_s_cnt   <= '0;
                            r_bit_cnt <= '0;
                            r_state   <= r_rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_s_cnt <= r_s_cnt + S_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_sample) begin
                        r_s_cnt            <= '0;
                        r_shift[r_bit_cnt] <= r_rx_sync;
                        if (r_bit_cnt == r_dbit_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= parity_enabled(r_par_mode) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + S_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (w_sample) begin
                        r_s_cnt   <= '0;
                        r_par_err <= w_par_err;
                        r_state   <= ST_STOP;
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + S_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_sample) begin
                        r_s_cnt <= '0;
                        if (!r_rx_sync) r_frame_err <= 1'b1;
                        if (r_bit_cnt == w_stop_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else if (w_s_tick) begin
                        r_s_cnt <= r_s_cnt + S_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // ---------------- receive FIFO ----------------
    logic [ENTRY_W-1:0] w_head;

    fifo #(
        .B (ENTRY_W),
        .W (FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_rd    (rd_uart),
        .i_wr    (w_push),
        .i_wdata (w_entry),
        .o_empty (rx_empty),
        .o_full  (rx_full),
        .o_rdata (w_head)
    );

    assign rd_data       = w_head[7:0];
    assign rd_parity_err = w_head[8];
    assign rd_frame_err  = w_head[9];

    // ---------------- sticky overrun ----------------
    logic r_overrun;
    logic w_drop;

    assign w_drop = w_push && rx_full && !rd_uart;

    always_ff @(posedge clk) begin
        if (rst)              r_overrun <= 1'b0;
        else if (w_drop)      r_overrun <= 1'b1;
        else if (clr_overrun) r_overrun <= 1'b0;
    end

    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Brief    : Scoreboard bench for uart_rx_ctrl with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int OS     = 16;
    localparam int FIFO_W = 2;
    localparam int DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [15:0] cfg_dvsr = 16'd4;
    logic [1:0]  cfg_dbit = 2'b11;
    logic [1:0]  cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        clr_overrun = 1'b0;
    logic        mon_rd = 1'b0;
    logic        man_rd = 1'b0;
    logic        rd_uart;
    logic [7:0]  rd_data;
    logic        rd_parity_err;
    logic        rd_frame_err;
    logic        rx_empty;
    logic        rx_full;
    logic        overrun;

    assign rd_uart = mon_rd | man_rd;

    uart_rx_ctrl #(
        .OVERSAMPLE (OS),
        .DVSR_WIDTH (16),
        .FIFO_W     (FIFO_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .cfg_dvsr      (cfg_dvsr),
        .cfg_dbit      (cfg_dbit),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rd_uart       (rd_uart),
        .rd_data       (rd_data),
        .rd_parity_err (rd_parity_err),
        .rd_frame_err  (rd_frame_err),
        .rx_empty      (rx_empty),
        .rx_full       (rx_full),
        .overrun       (overrun),
        .clr_overrun   (clr_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [9:0] exp_q[$];
    bit         exp_overrun = 1'b0;
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO entry derived from the transmitted frame.
    function automatic void model_push(input logic [7:0] data, input int nb, input int par,
                                       input logic pbit, input int nstop, input logic s1,
                                       input logic s2, input bit pop_same);
        logic [7:0] mask = 8'((1 << nb) - 1);
        logic [7:0] d    = data & mask;
        int         ones = $countones(d) + int'(pbit);
        logic       pe   = 1'b0;
        logic       fe   = !s1 || (nstop == 2 && !s2);
        if (par == 1) pe = (ones % 2) != 0;
        if (par == 2) pe = (ones % 2) == 0;
        if (exp_q.size() >= DEPTH && !pop_same) exp_overrun = 1'b1;
        else exp_q.push_back({fe, pe, d});
    endfunction

    function automatic int bit_period();
        return OS * ((cfg_dvsr <= 16'd1) ? 1 : int'(cfg_dvsr));
    endfunction

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input int nb, input int par,
                              input logic pbit, input int nstop, input logic s1,
                              input logic s2, input bit pop_same);
        int   bp = bit_period();
        logic st [2];
        st[0] = s1;
        st[1] = s2;
        cfg_dbit   = 2'(nb - 5);
        cfg_parity = 2'(par);
        cfg_stop2  = (nstop == 2);
        model_push(data, nb, par, pbit, nstop, s1, s2, pop_same);
        hold(1'b0, bp);
        // Config already latched; scrambling it must not disturb this frame.
        cfg_dbit   = 2'($urandom);
        cfg_parity = 2'($urandom);
        cfg_stop2  = 1'($urandom);
        for (int i = 0; i < nb; i++) hold(data[i], bp);
        if (par == 1 || par == 2) hold(pbit, bp);
        for (int k = 0; k < nstop; k++) begin
            if (!st[k] && k == nstop - 1) begin
                hold(1'b0, (3 * bp) / 4);
                hold(1'b1, bp - (3 * bp) / 4);
            end else begin
                hold(st[k], bp);
            end
        end
        hold(1'b1, bp);
    endtask

    task automatic manual_pop(input string name);
        if (exp_q.size() == 0) check({name, "_nothing_expected"}, 32'(rx_empty), 32'd1);
        else check(name, 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(exp_q.pop_front()));
        man_rd = 1'b1;
        @(posedge clk);
        #1 man_rd = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || !rx_empty) && k < 400) begin
            @(posedge clk);
            k++;
        end
        #1;
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops and scores every entry the DUT presents while enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && !rx_empty) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got %0h expected none", {rd_frame_err, rd_parity_err, rd_data});
                end else begin
                    check("entry", 32'({rd_frame_err, rd_parity_err, rd_data}), 32'(exp_q.pop_front()));
                end
                mon_rd = 1'b1;
                @(posedge clk);
                #1 mon_rd = 1'b0;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_empty",   32'(rx_empty), 32'd1);
        check("rst_full",    32'(rx_full), 32'd0);
        check("rst_data",    32'(rd_data), 32'd0);
        check("rst_errs",    32'({rd_frame_err, rd_parity_err}), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // Basic 8N1 with latency bound from the start edge.
        cfg_dvsr = 16'd4;
        fork
            send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
            begin
                int k = 0;
                while (rx_empty && k < 700) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                check("latency_ok", 32'(k <= 10 * 64 + 4), 32'd1);
            end
        join
        manual_pop("basic_8n1");
        check("basic_empty_after_pop", 32'(rx_empty), 32'd1);

        // 7E1 good and bad parity, then 8N2 framing error and recovery.
        mon_en = 1'b1;
        send_frame(8'h35, 7, 1, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h35, 7, 1, 1'b1, 1, 1'b1, 1'b1, 1'b0);
        wait_drain("parity_7e1");
        send_frame(8'h3C, 8, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        send_frame(8'hC3, 8, 0, 1'b0, 2, 1'b1, 1'b1, 1'b0);
        wait_drain("framing_8n2");

        // Glitch shorter than half a bit.
        rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check("glitch_empty", 32'(rx_empty), 32'd1);

        // Overrun with no reads.
        mon_en = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        check("ovr_full",    32'(rx_full), 32'd1);
        check("ovr_overrun", 32'(overrun), 32'(exp_overrun));
        clr_overrun = 1'b1;
        @(posedge clk);
        #1 clr_overrun = 1'b0;
        exp_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'(exp_overrun));
        mon_en = 1'b1;
        wait_drain("ovr_drain");
        mon_en = 1'b0;

        // Pop exactly when the fifth frame is pushed into a full FIFO.
        fork
            begin
                for (int i = 1; i <= 4; i++) send_frame(8'h10 + 8'(i), 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
                send_frame(8'h15, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b1);
            end
            begin
                int k  = 0;
                int c0;
                while (!rx_full && k < 4000) begin
                    @(negedge clk);
                    k++;
                end
                check("fill_full_seen", 32'(rx_full), 32'd1);
                c0 = cyc;
                // Frames are 704 cycles apart, a multiple of the tick period.
                while (cyc < c0 + 703) begin
                    @(posedge clk);
                    #1;
                end
                manual_pop("pop_at_full");
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("popfull_no_overrun", 32'(overrun), 32'd0);
        check("popfull_still_full", 32'(rx_full), 32'd1);
        send_frame(8'h66, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        check("second_overrun", 32'(overrun), 32'(exp_overrun));

        // Reset during data bit 3.
        hold(1'b0, 64);
        hold(1'b1, 64);
        hold(1'b0, 64);
        hold(1'b1, 64);
        hold(1'b0, 32);
        rx  = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        exp_overrun = 1'b0;
        repeat (12 * 64) @(posedge clk);
        #1;
        check("midrst_empty",   32'(rx_empty), 32'd1);
        check("midrst_full",    32'(rx_full), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_data",    32'(rd_data), 32'd0);
        mon_en = 1'b1;
        send_frame(8'h5A, 8, 0, 1'b0, 1, 1'b1, 1'b1, 1'b0);
        wait_drain("after_reset");

        // Randomised frames across divisors and frame formats.
        for (int f = 0; f < 24; f++) begin
            cfg_dvsr = 16'($urandom_range(0, 5));
            send_frame(8'($urandom), int'($urandom_range(5, 8)), int'($urandom_range(0, 3)),
                       1'($urandom), int'($urandom_range(1, 2)),
                       $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0, 1'b0);
        end
        wait_drain("random");
        check("final_overrun", 32'(overrun), 32'(exp_overrun));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
